// File: rtl/ctrl_pkg.sv
// ctrl_pkg -- shared definitions for control_fsm and the datapath users.
//   state_t      : controller state encoding (S_ERR exists only when
//                  CTRL_ILLEGAL_TRAP_EN is defined)
//   OPC_* / OP_* : instruction class and sub-operation codes
//   NSEL_*       : one-hot register-select encodings
//   VSEL_*       : one-hot writeback-source encodings
//   instr_cls_t / decode_instr() : opcode/op classification helper
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_WAIT   = 4'd0,
        S_DECODE = 4'd1,
        S_GET_A  = 4'd2,
        S_GET_B  = 4'd3,
        S_EXEC   = 4'd4,
        S_CMP    = 4'd5,
        S_WR_IMM = 4'd6,
        S_WR_REG = 4'd7
`ifdef CTRL_ILLEGAL_TRAP_EN
        , S_ERR  = 4'd8
`endif
    } state_t;

    localparam logic [2:0] OPC_MOV    = 3'b110;
    localparam logic [2:0] OPC_ALU    = 3'b101;

    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [2:0] NSEL_RM    = 3'b001;
    localparam logic [2:0] NSEL_RD    = 3'b010;
    localparam logic [2:0] NSEL_RN    = 3'b100;

    localparam logic [3:0] VSEL_MDATA  = 4'b0001;
    localparam logic [3:0] VSEL_SXIMM8 = 4'b0010;
    localparam logic [3:0] VSEL_PC     = 4'b0100;
    localparam logic [3:0] VSEL_C      = 4'b1000;

    typedef enum logic [2:0] {
        CLS_MOVI = 3'd0,
        CLS_MOVR = 3'd1,
        CLS_ADD  = 3'd2,
        CLS_CMP  = 3'd3,
        CLS_AND  = 3'd4,
        CLS_MVN  = 3'd5,
        CLS_ILL  = 3'd6
    } instr_cls_t;

    function automatic instr_cls_t decode_instr(input logic [2:0] opc, input logic [1:0] sub);
        instr_cls_t c;
        c = CLS_ILL;
        if (opc == OPC_MOV) begin
            if (sub == OP_MOV_IMM)      c = CLS_MOVI;
            else if (sub == OP_MOV_REG) c = CLS_MOVR;
        end else if (opc == OPC_ALU) begin
            case (sub)
                OP_ADD:  c = CLS_ADD;
                OP_CMP:  c = CLS_CMP;
                OP_AND:  c = CLS_AND;
                default: c = CLS_MVN;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/control_fsm.sv
// control_fsm -- Moore sequencer driving the register-file/ALU datapath.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   s                 : start strobe, only looked at in WAIT
//   opcode[2:0], op[1:0] : instruction class / sub-operation
//   w                 : idle flag, high only in WAIT
//   nsel[2:0], vsel[3:0] : one-hot register select / writeback source
//   loada, loadb, loadc, loads, write : datapath strobes
//   asel, bsel        : ALU operand selects
//   err               : illegal-instruction flag
// Build option: CTRL_ILLEGAL_TRAP_EN -- when defined an illegal decode
// parks the FSM in ERR (err=1) until reset; otherwise it returns to WAIT
// silently and err is tied low.
module control_fsm
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       s,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic       w,
    output logic [2:0] nsel,
    output logic [3:0] vsel,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       write,
    output logic       asel,
    output logic       bsel,
    output logic       err
);

    state_t     state, nxt;
    logic [2:0] opc_q;
    logic [1:0] op_q;
    instr_cls_t cls_in, cls_q;

    // DECODE branches on the live inputs; every later state uses the copy
    // captured on the edge leaving DECODE, so input changes mid-instruction
    // cannot redirect the sequence.
    assign cls_in = decode_instr(opcode, op);
    assign cls_q  = decode_instr(opc_q, op_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_WAIT;
            opc_q <= 3'b000;
            op_q  <= 2'b00;
        end else begin
            state <= nxt;
            if (state == S_DECODE) begin
                opc_q <= opcode;
                op_q  <= op;
            end
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            S_WAIT:   nxt = s ? S_DECODE : S_WAIT;
            S_DECODE: begin
                case (cls_in)
                    CLS_MOVI:                 nxt = S_WR_IMM;
                    CLS_MOVR, CLS_MVN:        nxt = S_GET_B;
                    CLS_ADD, CLS_AND, CLS_CMP: nxt = S_GET_A;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    default:                  nxt = S_ERR;
`else
                    default:                  nxt = S_WAIT;
`endif
                endcase
            end
            S_GET_A:  nxt = S_GET_B;
            S_GET_B:  nxt = (cls_q == CLS_CMP) ? S_CMP : S_EXEC;
            S_EXEC:   nxt = S_WR_REG;
            S_CMP:    nxt = S_WAIT;
            S_WR_IMM: nxt = S_WAIT;
            S_WR_REG: nxt = S_WAIT;
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_ERR:    nxt = S_ERR;
`endif
            default:  nxt = S_WAIT;
        endcase
    end

    // Raw Moore decode; strobes are gated by reset below.
    logic la, lb, lc, ls, wr;

    always_comb begin
        w    = 1'b0;
        nsel = NSEL_RM;
        vsel = VSEL_C;
        la   = 1'b0;
        lb   = 1'b0;
        lc   = 1'b0;
        ls   = 1'b0;
        wr   = 1'b0;
        asel = 1'b0;
        bsel = 1'b0;
        case (state)
            S_WAIT:   w = 1'b1;
            S_GET_A:  begin nsel = NSEL_RN; la = 1'b1; end
            S_GET_B:  begin nsel = NSEL_RM; lb = 1'b1; end
            S_EXEC:   begin lc = 1'b1; asel = (cls_q == CLS_MOVR); end
            S_CMP:    ls = 1'b1;
            S_WR_IMM: begin nsel = NSEL_RN; vsel = VSEL_SXIMM8; wr = 1'b1; end
            S_WR_REG: begin nsel = NSEL_RD; vsel = VSEL_C; wr = 1'b1; end
            default:  ;
        endcase
    end

    // Reset suppresses strobes in the same cycle so an aborted instruction
    // never lands a load or write.
    assign loada = la & ~reset;
    assign loadb = lb & ~reset;
    assign loadc = lc & ~reset;
    assign loads = ls & ~reset;
    assign write = wr & ~reset;

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign err = (state == S_ERR) & ~reset;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_control_fsm.sv
module tb_control_fsm;

    logic       clk = 1'b0;
    logic       reset, s;
    logic [2:0] opcode;
    logic [1:0] op;
    logic       w, loada, loadb, loadc, loads, write, asel, bsel, err;
    logic [2:0] nsel;
    logic [3:0] vsel;

    int vectors = 0;
    int miscompares = 0;

    control_fsm dut (
        .clk(clk), .reset(reset), .s(s), .opcode(opcode), .op(op),
        .w(w), .nsel(nsel), .vsel(vsel),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .write(write), .asel(asel), .bsel(bsel), .err(err)
    );

    always #5 clk = ~clk;

    // {w, nsel, vsel, loada, loadb, loadc, loads, write, asel, bsel, err}
    logic [15:0] obs;
    assign obs = {w, nsel, vsel, loada, loadb, loadc, loads, write, asel, bsel, err};

    localparam logic [15:0] E_WAIT   = {1'b1, 3'b001, 4'b1000, 7'b0000000, 1'b0};
    localparam logic [15:0] E_DEC    = {1'b0, 3'b001, 4'b1000, 7'b0000000, 1'b0};
    localparam logic [15:0] E_GETA   = {1'b0, 3'b100, 4'b1000, 7'b1000000, 1'b0};
    localparam logic [15:0] E_GETB   = {1'b0, 3'b001, 4'b1000, 7'b0100000, 1'b0};
    localparam logic [15:0] E_EXEC0  = {1'b0, 3'b001, 4'b1000, 7'b0010000, 1'b0};
    localparam logic [15:0] E_EXEC1  = {1'b0, 3'b001, 4'b1000, 7'b0010010, 1'b0};
    localparam logic [15:0] E_CMP    = {1'b0, 3'b001, 4'b1000, 7'b0001000, 1'b0};
    localparam logic [15:0] E_WRIMM  = {1'b0, 3'b100, 4'b0010, 7'b0000100, 1'b0};
    localparam logic [15:0] E_WRREG  = {1'b0, 3'b010, 4'b1000, 7'b0000100, 1'b0};
    localparam logic [15:0] E_ERR    = {1'b0, 3'b001, 4'b1000, 7'b0000000, 1'b1};
    // GET_B while reset is high: loadb masked, everything else unchanged
    localparam logic [15:0] E_GETB_R = {1'b0, 3'b001, 4'b1000, 7'b0000000, 1'b0};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; s = 1'b1; opcode = 3'b110; op = 2'b10;
        step();
        step();
        vectors++;
        if (obs !== E_WAIT) begin
            miscompares++;
            $display("FAIL reset_state got=%b exp=%b", obs, E_WAIT);
        end
        reset = 1'b0; s = 1'b0;
        step();
        vectors++;
        if (obs !== E_WAIT) begin
            miscompares++;
            $display("FAIL reset_idle got=%b exp=%b", obs, E_WAIT);
        end
    endtask

    task automatic test_mov_imm();
        logic [15:0] exp [3];
        exp = '{E_DEC, E_WRIMM, E_WAIT};
        s = 1'b1; opcode = 3'b110; op = 2'b10;
        for (int i = 0; i < 3; i++) begin
            step();
            s = 1'b0;
            vectors++;
            if (obs !== exp[i]) begin
                miscompares++;
                $display("FAIL mov_imm edge%0d got=%b exp=%b", i + 1, obs, exp[i]);
            end
        end
    endtask

    task automatic test_add();
        logic [15:0] exp [6];
        exp = '{E_DEC, E_GETA, E_GETB, E_EXEC0, E_WRREG, E_WAIT};
        s = 1'b1; opcode = 3'b101; op = 2'b00;
        for (int i = 0; i < 6; i++) begin
            step();
            s = 1'b0;
            vectors++;
            if (obs !== exp[i]) begin
                miscompares++;
                $display("FAIL add edge%0d got=%b exp=%b", i + 1, obs, exp[i]);
            end
        end
    endtask

    task automatic test_cmp();
        logic [15:0] exp [5];
        exp = '{E_DEC, E_GETA, E_GETB, E_CMP, E_WAIT};
        s = 1'b1; opcode = 3'b101; op = 2'b01;
        for (int i = 0; i < 5; i++) begin
            step();
            s = 1'b0;
            vectors++;
            if (obs !== exp[i]) begin
                miscompares++;
                $display("FAIL cmp edge%0d got=%b exp=%b", i + 1, obs, exp[i]);
            end
        end
    endtask

    task automatic test_mov_reg();
        logic [15:0] exp [5];
        exp = '{E_DEC, E_GETB, E_EXEC1, E_WRREG, E_WAIT};
        s = 1'b1; opcode = 3'b110; op = 2'b00;
        for (int i = 0; i < 5; i++) begin
            step();
            s = 1'b0;
            // switch to a CMP encoding while in GET_B; must not matter
            if (i == 1) begin opcode = 3'b101; op = 2'b01; end
            vectors++;
            if (obs !== exp[i]) begin
                miscompares++;
                $display("FAIL mov_reg edge%0d got=%b exp=%b", i + 1, obs, exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp [9];
        exp = '{E_DEC, E_GETA, E_GETB, E_EXEC0, E_WRREG, E_WAIT, E_DEC, E_GETA, E_GETB};
        s = 1'b1; opcode = 3'b101; op = 2'b00;
        for (int i = 0; i < 9; i++) begin
            step();
            vectors++;
            if (obs !== exp[i]) begin
                miscompares++;
                $display("FAIL b2b edge%0d got=%b exp=%b", i + 1, obs, exp[i]);
            end
        end
        // abort the second ADD in GET_B
        reset = 1'b1;
        #1;
        vectors++;
        if (obs !== E_GETB_R) begin
            miscompares++;
            $display("FAIL b2b_reset_mask got=%b exp=%b", obs, E_GETB_R);
        end
        step();
        reset = 1'b0; s = 1'b0;
        vectors++;
        if (obs !== E_WAIT) begin
            miscompares++;
            $display("FAIL b2b_abort got=%b exp=%b", obs, E_WAIT);
        end
        step();
        vectors++;
        if (obs !== E_WAIT) begin
            miscompares++;
            $display("FAIL b2b_no_write got=%b exp=%b", obs, E_WAIT);
        end
    endtask

    task automatic test_illegal(input logic [2:0] opc, input logic [1:0] sub);
`ifdef CTRL_ILLEGAL_TRAP_EN
        logic [15:0] exp [4];
        exp = '{E_DEC, E_ERR, E_ERR, E_ERR};
`else
        logic [15:0] exp [4];
        exp = '{E_DEC, E_WAIT, E_WAIT, E_WAIT};
`endif
        s = 1'b1; opcode = opc; op = sub;
        for (int i = 0; i < 4; i++) begin
            step();
            // keep s low after the start edge so the non-trap build idles
            s = 1'b0;
            vectors++;
            if (obs !== exp[i]) begin
                miscompares++;
                $display("FAIL illegal_%b_%b edge%0d got=%b exp=%b", opc, sub, i + 1, obs, exp[i]);
            end
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_reset_err got=%b exp=0", err);
        end
        step();
        reset = 1'b0;
        vectors++;
        if (obs !== E_WAIT) begin
            miscompares++;
            $display("FAIL illegal_recover got=%b exp=%b", obs, E_WAIT);
        end
    endtask

    initial begin
        reset = 1'b1; s = 1'b0; opcode = 3'b000; op = 2'b00;
        test_reset();
        test_mov_imm();
        test_add();
        test_cmp();
        test_mov_reg();
        test_back_to_back();
        test_illegal(3'b111, 2'b00);
        test_illegal(3'b110, 2'b11);
        test_add();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
